// File: rtl/dmem_bridge.sv
// Data-memory responder for the single-cycle CPU: word RAM plus LED, switch and
// timer registers, with combinational read data.
module dmem_bridge #(
  parameter int DM_WORDS = 128,
  parameter int SW_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemWrite,
  input  logic [31:0]     addr,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  input  logic [SW_W-1:0] sw_i,
  output logic [SW_W-1:0] led_o,
  output logic            timer_irq
);

  localparam int          AW        = $clog2(DM_WORDS);
  localparam logic [31:0] ADDR_LED  = 32'h0000_7F00;
  localparam logic [31:0] ADDR_SW   = 32'h0000_7F04;
  localparam logic [31:0] ADDR_CTRL = 32'h0000_7F10;
  localparam logic [31:0] ADDR_LOAD = 32'h0000_7F14;
  localparam logic [31:0] ADDR_CNT  = 32'h0000_7F18;
  localparam logic [31:0] ADDR_STAT = 32'h0000_7F1C;

  logic [31:0]     mem [DM_WORDS];
  logic [31:0]     a_w;
  logic            ram_sel;
  logic [AW-1:0]   ram_idx;
  logic            unused_lsb;

  logic [SW_W-1:0] led_q, sw_s1_q, sw_s2_q;
  logic            en_q, rld_q, flag_q, flag_d;
  logic [31:0]     load_q, load_d, count_q, count_d;
  logic            wr_led, wr_ctrl, wr_load, wr_cnt, wr_stat, expire;

  assign a_w        = {addr[31:2], 2'b00};
  assign ram_sel    = (a_w < 32'(4 * DM_WORDS));
  assign ram_idx    = addr[AW+1:2];
  assign unused_lsb = ^addr[1:0];

  assign wr_led  = MemWrite && (a_w == ADDR_LED);
  assign wr_ctrl = MemWrite && (a_w == ADDR_CTRL);
  assign wr_load = MemWrite && (a_w == ADDR_LOAD);
  assign wr_cnt  = MemWrite && (a_w == ADDR_CNT);
  assign wr_stat = MemWrite && (a_w == ADDR_STAT);

  // RAM has no reset so it survives a reset pulse.
  always_ff @(posedge clk) begin
    if (MemWrite && ram_sel) mem[ram_idx] <= writedata;
  end

  // CPU writes to LOAD/COUNT take precedence over counting; expiry beats a flag clear.
  always_comb begin
    load_d  = load_q;
    count_d = count_q;
    expire  = 1'b0;
    if (wr_load) begin
      load_d  = writedata;
      count_d = writedata;
    end else if (wr_cnt) begin
      count_d = writedata;
    end else if (en_q && count_q != 32'd0) begin
      if (count_q == 32'd1) begin
        count_d = rld_q ? load_q : 32'd0;
        expire  = 1'b1;
      end else begin
        count_d = count_q - 32'd1;
      end
    end
    flag_d = flag_q;
    if (expire)                     flag_d = 1'b1;
    else if (wr_stat && writedata[0]) flag_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q   <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      en_q    <= 1'b0;
      rld_q   <= 1'b0;
      load_q  <= '0;
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      sw_s1_q <= sw_i;
      sw_s2_q <= sw_s1_q;
      if (wr_led) led_q <= writedata[SW_W-1:0];
      if (wr_ctrl) begin
        en_q  <= writedata[0];
        rld_q <= writedata[1];
      end
      load_q  <= load_d;
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    readdata = '0;
    if (ram_sel) begin
      readdata = mem[ram_idx];
    end else begin
      case (a_w)
        ADDR_LED:  readdata = 32'(led_q);
        ADDR_SW:   readdata = 32'(sw_s2_q);
        ADDR_CTRL: readdata = {30'd0, rld_q, en_q};
        ADDR_LOAD: readdata = load_q;
        ADDR_CNT:  readdata = count_q;
        ADDR_STAT: readdata = {31'd0, flag_q};
        default:   readdata = '0;
      endcase
    end
  end

  assign led_o     = led_q;
  assign timer_irq = flag_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomised and directed bench for dmem_bridge against a register-map model.
module tb_dmem_bridge;
  localparam int DM_WORDS = 128;
  localparam int SW_W     = 16;
  localparam logic [31:0] LED = 32'h7F00, SW = 32'h7F04, CTRL = 32'h7F10,
                          LOAD = 32'h7F14, CNT = 32'h7F18, STAT = 32'h7F1C;

  logic            clk, rst, MemWrite;
  logic [31:0]     addr, writedata, readdata;
  logic [SW_W-1:0] sw_i, led_o;
  logic            timer_irq;

  int checks = 0, errors = 0;

  // Model state
  logic [31:0]     m_ram [DM_WORDS];
  logic [SW_W-1:0] m_led, m_s1, m_s2;
  bit              m_en, m_rld, m_flag;
  logic [31:0]     m_load, m_count;

  dmem_bridge #(.DM_WORDS(DM_WORDS), .SW_W(SW_W)) dut (
    .clk(clk), .rst(rst), .MemWrite(MemWrite), .addr(addr), .writedata(writedata),
    .readdata(readdata), .sw_i(sw_i), .led_o(led_o), .timer_irq(timer_irq)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_led = '0; m_s1 = '0; m_s2 = '0; m_en = 0; m_rld = 0;
    m_load = 0; m_count = 0; m_flag = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w < 4 * DM_WORDS) return m_ram[w / 4];
    if (w == LED)  return 32'(m_led);
    if (w == SW)   return 32'(m_s2);
    if (w == CTRL) return {30'd0, m_rld, m_en};
    if (w == LOAD) return m_load;
    if (w == CNT)  return m_count;
    if (w == STAT) return {31'd0, m_flag};
    return 32'd0;
  endfunction

  task automatic model_edge(input bit we, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w;
    bit expired;
    w = a & 32'hFFFF_FFFC;
    expired = 0;
    m_s2 = m_s1;
    m_s1 = sw_i;
    if (we && w < 4 * DM_WORDS) m_ram[w / 4] = wd;
    if (we && w == LOAD) begin
      m_load = wd; m_count = wd;
    end else if (we && w == CNT) begin
      m_count = wd;
    end else if (m_en && m_count == 1) begin
      m_count = m_rld ? m_load : 0;
      expired = 1;
    end else if (m_en && m_count > 1) begin
      m_count = m_count - 1;
    end
    if (expired) m_flag = 1;
    else if (we && w == STAT && wd[0]) m_flag = 0;
    if (we && w == CTRL) begin m_en = wd[0]; m_rld = wd[1]; end
    if (we && w == LED) m_led = wd[SW_W-1:0];
  endtask

  // One bus cycle: rd is readdata sampled before the edge; model advanced at the edge.
  task automatic bus(input bit we, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd);
    @(negedge clk);
    MemWrite = we; addr = a; writedata = wd;
    #1 rd = readdata;
    @(posedge clk);
    model_edge(we, a, wd);
    #1 MemWrite = 0;
  endtask

  task automatic test_reset();
    rst = 0; MemWrite = 0; addr = LED; writedata = 0; sw_i = '0;
    model_reset();
    #1;
    checks++; if (led_o !== '0) begin errors++; $display("FAIL reset_led got %h want 0", led_o); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", timer_irq); end
    checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL reset_led_rd got %h want 0", readdata); end
    addr = CNT; #1;
    checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL reset_cnt_rd got %h want 0", readdata); end
    repeat (2) @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_ram();
    logic [31:0] rd;
    bus(1, 32'h10, 32'hDEADBEEF, rd);
    bus(0, 32'h10, 0, rd);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_rd10 got %h want deadbeef", rd); end
    bus(0, 32'h13, 0, rd);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_rd13 got %h want deadbeef", rd); end
    bus(0, 32'h14, 0, rd);
    checks++; if (rd === 32'hDEADBEEF) begin errors++; $display("FAIL ram_rd14 got %h want not deadbeef", rd); end
    // store and load in same cycle: load sees the old value
    bus(1, 32'h10, 32'h1111_2222, rd);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_rdw got %h want deadbeef", rd); end
    bus(1, 32'h10, 32'hDEADBEEF, rd);
    checks++; if (rd !== 32'h1111_2222) begin errors++; $display("FAIL ram_rdw2 got %h want 11112222", rd); end
  endtask

  task automatic test_led_reset();
    logic [31:0] rd;
    bus(1, LED, 32'h0000_A5A5, rd);
    checks++; if (led_o !== 16'hA5A5) begin errors++; $display("FAIL led_set got %h want a5a5", led_o); end
    bus(1, CTRL, 1, rd);
    bus(1, LOAD, 2, rd);
    bus(0, CNT, 0, rd);
    bus(0, CNT, 0, rd);
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL pre_rst_irq got %b want 1", timer_irq); end
    bus(1, LOAD, 40, rd);
    addr = CNT;
    #2 rst = 0; model_reset();
    #1;
    checks++; if (led_o !== '0) begin errors++; $display("FAIL rst_led got %h want 0", led_o); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b want 0", timer_irq); end
    checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL rst_cnt got %h want 0", readdata); end
    addr = 32'h10; #1;
    checks++; if (readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_ram got %h want deadbeef", readdata); end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_sw();
    logic [31:0] rd;
    sw_i = 16'h00F0;
    bus(0, SW, 0, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL sw_e0 got %h want 0", rd); end
    bus(0, SW, 0, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL sw_e1 got %h want 0", rd); end
    bus(0, SW, 0, rd);
    checks++; if (rd !== 32'h0000_00F0) begin errors++; $display("FAIL sw_e2 got %h want f0", rd); end
  endtask

  task automatic test_timer_oneshot();
    logic [31:0] rd;
    logic [31:0] exp_seq [5] = '{3, 2, 1, 0, 0};
    bus(1, STAT, 1, rd);
    bus(1, CTRL, 1, rd);
    bus(1, LOAD, 3, rd);
    for (int i = 0; i < 5; i++) begin
      bus(0, CNT, 0, rd);
      checks++;
      if (rd !== exp_seq[i]) begin errors++; $display("FAIL oneshot_cnt%0d got %0d want %0d", i, rd, exp_seq[i]); end
      if (i == 2) begin
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq got %b want 1", timer_irq); end
      end
    end
    bus(0, STAT, 0, rd);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL oneshot_stat got %h want 1", rd); end
  endtask

  task automatic test_timer_reload();
    logic [31:0] rd;
    logic [31:0] exp_seq [4] = '{2, 1, 2, 1};
    int guard;
    bus(1, STAT, 1, rd);
    bus(1, CTRL, 3, rd);
    bus(1, LOAD, 2, rd);
    for (int i = 0; i < 4; i++) begin
      bus(0, CNT, 0, rd);
      checks++;
      if (rd !== exp_seq[i]) begin errors++; $display("FAIL reload_cnt%0d got %0d want %0d", i, rd, exp_seq[i]); end
    end
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL reload_irq got %b want 1", timer_irq); end
    guard = 0;
    while (m_count != 1 && guard < 10) begin bus(0, CNT, 0, rd); guard++; end
    checks++; if (guard >= 10) begin errors++; $display("FAIL reload_sync got timeout want count 1"); end
    bus(1, STAT, 1, rd);
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL set_beats_clr got %b want 1", timer_irq); end
    bus(1, STAT, 1, rd);
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL stat_clr got %b want 0", timer_irq); end
  endtask

  task automatic test_count_override();
    logic [31:0] rd;
    bus(1, CTRL, 1, rd);
    bus(1, LOAD, 50, rd);
    bus(0, CNT, 0, rd);
    bus(1, CNT, 10, rd);
    bus(0, CNT, 0, rd);
    checks++; if (rd !== 32'd10) begin errors++; $display("FAIL cnt_override got %0d want 10", rd); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd, led_before;
    bus(1, 32'h0, 32'h1234_5678, rd);
    bus(1, CTRL, 0, rd);
    led_before = m_read(LED);
    bus(1, 32'h7F08, 32'hFFFF_FFFF, rd);
    bus(1, 32'h1000_0000, 32'hCAFE_F00D, rd);
    bus(0, 32'h7F08, 0, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL unmap_7f08 got %h want 0", rd); end
    bus(0, 32'h1000_0000, 0, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL unmap_1000 got %h want 0", rd); end
    bus(0, 32'h0, 0, rd);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL unmap_ram0 got %h want 12345678", rd); end
    bus(0, LED, 0, rd);
    checks++; if (rd !== led_before) begin errors++; $display("FAIL unmap_led got %h want %h", rd, led_before); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, exp;
    bit we;
    for (int i = 0; i < 16; i++) bus(1, 32'(i * 4), $urandom, rd);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) sw_i = SW_W'($urandom);
      we = $urandom_range(0, 1);
      case ($urandom_range(0, 9))
        0, 1:    a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
        2:       a = LED;
        3:       a = SW;
        4:       a = CTRL;
        5:       a = LOAD;
        6:       a = CNT;
        7:       a = STAT;
        8:       a = 32'h7F08;
        default: a = 32'h0001_0000 | 32'($urandom);
      endcase
      wd = (a == LOAD || a == CNT) ? 32'($urandom_range(0, 5)) :
           (a == CTRL) ? 32'($urandom_range(0, 3)) : $urandom;
      exp = m_read(a);
      bus(we, a, wd, rd);
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL rand_rd a=%h got %h want %h", a, rd, exp); end
      checks++;
      if (led_o !== m_led || timer_irq !== m_flag) begin
        errors++; $display("FAIL rand_out got led=%h irq=%b want led=%h irq=%b", led_o, timer_irq, m_led, m_flag);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led_reset();
    test_sw();
    test_timer_oneshot();
    test_timer_reload();
    test_count_override();
    test_unmapped();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Responder side of the single-cycle CPU's data-memory port: it takes the CPU's address, write-data and write-enable outputs and returns read data in the same cycle. It contains a word-addressed data RAM, an LED output register, a synchronised switch input and a down-counting timer with a sticky expiry flag. It sits between the CPU core and the board-level pins, in place of a bare data memory.

## Interface
- DM_WORDS, 128, RAM depth in 32-bit words; power of two; at most 2048, so RAM ends below 0x7F00.
- SW_W, 16, switch/LED width; at most 32.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- MemWrite  in  1  write strobe from the CPU.
- addr  in  32  byte address (CPU ALU output); addr[1:0] ignored.
- writedata  in  32  store data.
- readdata  out  32  load data; combinational from addr and current state.
- sw_i  in  SW_W  asynchronous board switches.
- led_o  out  SW_W  LED register.
- timer_irq  out  1  expiry flag (the status register's bit 0).

## Operation
- Decode uses word address A = {addr[31:2], 2'b00}.
- RAM: A < 4*DM_WORDS; word index addr[log2(DM_WORDS)+1:2].
  - Read and write.
  - Contents are not reset.
- 0x7F00 LED: read/write; led_o = reg[SW_W-1:0].
- 0x7F04 SW: read-only; returns the 2-flop synchronised sw_i, zero-extended.
- 0x7F10 CTRL: read/write; bit0 EN, bit1 RELOAD; other bits read 0.
- 0x7F14 LOAD: read/write 32-bit reload value. A write also sets COUNT to writedata.
- 0x7F18 COUNT: read/write.
- 0x7F1C STAT: bit0 FLAG. Writing 1 to bit0 clears it; writing 0 has no effect.
- Any other address: reads return 0; writes are ignored.
- Timer, per cycle with EN=1 and no CPU write to COUNT/LOAD:
  - COUNT>1: COUNT decrements by 1.
  - COUNT==1: COUNT becomes LOAD if RELOAD=1, else 0; FLAG is set.
  - COUNT==0: COUNT holds; FLAG is unchanged.
- EN=0: COUNT holds.
- Priority and simultaneous events:
  - A CPU write to COUNT or LOAD overrides the decrement in that cycle.
  - If expiry and a STAT clear happen in the same cycle, the set wins and FLAG stays 1.
  - Writing CTRL takes effect from the next edge: the new EN governs the cycle after the write.

## Timing
- Reads are combinational. A load issued in the same cycle as a store to the same address returns the old value; the new value is visible after the edge.
- Stores commit on the rising edge where MemWrite=1.
- SW read latency: a sw_i change is visible on readdata 2 rising edges later.
- Timer: after a LOAD write of N with EN=1 already set, FLAG rises on edge N after the write edge, and timer_irq goes high at the same time.
- Asserting rst (low) at any time, including while the timer is running, immediately clears all of the following:
  - LED, CTRL, LOAD, COUNT, FLAG and both sync flops become 0.
  - led_o and timer_irq become 0.
  - RAM is untouched.
- readdata at reset: RAM reads return the stored value; register reads return 0.
- Release of rst is synchronised by the system; the block needs no extra deassertion logic.

## Test plan
- Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 and 0x0000_0013 -> readdata = 0xDEADBEEF for both. Load 0x0000_0014 -> the old/unwritten value, not 0xDEADBEEF.
- Store 0x0000_A5A5 to 0x7F00 -> led_o = 0xA5A5 after the edge. Assert rst mid-run -> led_o = 0 immediately, and the RAM word at 0x10 still reads 0xDEADBEEF.
- Set sw_i = 0x00F0 -> a read of 0x7F04 returns 0 for 2 edges, then 0x000000F0.
- Write CTRL = 1, then LOAD = 3 -> COUNT reads 3, 2, 1 on successive cycles, then 0 with FLAG = 1 and timer_irq = 1. COUNT then stays 0.
- Write CTRL = 3, LOAD = 2 -> FLAG is set every 2 cycles and COUNT cycles 2, 1, 2, 1. A STAT write of 1 in the cycle where COUNT = 1 -> FLAG stays 1. A STAT write of 1 when COUNT = 2 -> FLAG = 0.
- Write COUNT = 10 while the timer is running -> the next read is 10, not 9. Writes to 0x7F08 and 0x1000_0000 -> no state change, and both read 0.
